abs_frame_accumulator: RTL and testbench



---
 rtl/abs_frame_accumulator_if.sv | 30 +++
 rtl/abs_frame_accumulator.sv | 112 +++++++++++
 tb/tb_abs_frame_accumulator.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/abs_frame_accumulator_if.sv
// abs_frame_accumulator_if
//   Handshake bundle for abs_frame_accumulator.
//   master : frame producer / result consumer (drives start, in_valid,
//            in_data, out_ready; observes in_ready, out_valid, out_sum,
//            out_max, busy)
//   slave  : the accumulator itself
interface abs_frame_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 11
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic              busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_max, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_max, busy
    );
endinterface

// File: rtl/abs_frame_accumulator.sv
// abs_frame_accumulator
//   Takes a frame of COUNT signed samples over a valid/ready handshake,
//   sums their magnitudes and tracks the peak magnitude, then presents
//   {sum, max} on an output valid/ready handshake.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - slave side of abs_frame_accumulator_if
//            (start, in_valid/in_data/in_ready, out_valid/out_ready,
//             out_sum, out_max, busy)
module abs_frame_accumulator #(
    parameter int DATA_W = 8,
    parameter int COUNT  = 8,
    parameter int SUM_W  = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    abs_frame_accumulator_if.slave  bus
);
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_max;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [DATA_W-1:0] w_mag;
    logic [SUM_W-1:0]  w_mag_ext;
    logic              w_accept;

    // Two's-complement magnitude; the most negative value maps onto itself
    // and is read as unsigned (0x80 -> 128).
    always_comb begin
        w_mag = bus.in_data;
        if (bus.in_data[DATA_W-1]) begin
            w_mag = (~bus.in_data) + 1'b1;
        end
    end

    assign w_mag_ext = {{(SUM_W-DATA_W){1'b0}}, w_mag};
    assign w_accept  = bus.in_valid && r_in_ready;

    // Handshake flags are registered together with the state so that
    // neither in_valid nor out_ready has a combinational path to an output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sum       <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_ACCUM;
                        r_sum      <= '0;
                        r_max      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_sum <= r_sum + w_mag_ext;
                        if (w_mag > r_max) begin
                            r_max <= w_mag;
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_max   = r_max;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_abs_frame_accumulator.sv
// tb_abs_frame_accumulator
//   Scoreboard bench: each frame's expected {sum, max} is pushed when the
//   frame is driven and popped when the DUT raises out_valid.
module tb_abs_frame_accumulator;
    localparam int DATA_W = 8;
    localparam int COUNT  = 8;
    localparam int SUM_W  = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    abs_frame_accumulator_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

    abs_frame_accumulator #(
        .DATA_W (DATA_W),
        .COUNT  (COUNT),
        .SUM_W  (SUM_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [SUM_W-1:0]  sum;
        logic [DATA_W-1:0] max;
    } exp_t;

    typedef logic [7:0] frame_t [COUNT];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    frame_t f_ff, f_mix, f_80, f_02;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input frame_t f);
        exp_t r;
        int   s;
        int   m;
        int   v;
        s = 0;
        m = 0;
        for (int i = 0; i < COUNT; i++) begin
            v = $signed(f[i]);
            if (v < 0) v = -v;
            s += v;
            if (v > m) m = v;
        end
        r.sum = s[SUM_W-1:0];
        r.max = m[DATA_W-1:0];
        return r;
    endfunction

    // Drives one frame; optional random gaps and start pulses inside ACCUM.
    task automatic send_frame(input frame_t f, input bit gaps, input bit mid_start);
        sb.push_back(model(f));
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL in_ready_after_start: got %b want 1", bus.in_ready);
            n_err++;
        end
        for (int i = 0; i < COUNT; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick;
            if (mid_start && i == 3) begin
                bus.start = 1'b1;
                tick;
                bus.start = 1'b0;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            if (mid_start && i == 5) bus.start = 1'b1;
            tick;
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            if (i == COUNT - 2) begin
                n_cmp++;
                if (bus.out_valid !== 1'b0) begin
                    $display("FAIL early_out_valid: got %b want 0", bus.out_valid);
                    n_err++;
                end
            end
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL latency_out_valid: got %b want 1", bus.out_valid);
            n_err++;
        end
    endtask

    task automatic collect(input string name);
        exp_t e;
        int   waited;
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            tick;
            waited++;
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL %s_timeout: out_valid=%b queued=%0d", name, bus.out_valid, sb.size());
            n_err++;
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (bus.out_sum !== e.sum) begin
            $display("FAIL %s_sum: got %0d want %0d", name, bus.out_sum, e.sum);
            n_err++;
        end
        n_cmp++;
        if (bus.out_max !== e.max) begin
            $display("FAIL %s_max: got 0x%02h want 0x%02h", name, bus.out_max, e.max);
            n_err++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL %s_done_flags: in_ready=%b busy=%b want 0/1", name, bus.in_ready, bus.busy);
            n_err++;
        end
    endtask

    task automatic release_out(input string name);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL %s_release: out_valid=%b busy=%b want 0/0", name, bus.out_valid, bus.busy);
            n_err++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_sum !== '0 || bus.out_max !== '0) begin
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b sum=%0d max=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_sum, bus.out_max);
            n_err++;
        end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        send_frame(f_ff, 1'b0, 1'b0);
        collect("all_ff");
        release_out("all_ff");
        send_frame(f_mix, 1'b0, 1'b0);
        collect("mixed");
        release_out("mixed");
        send_frame(f_80, 1'b0, 1'b0);
        collect("all_80");
        release_out("all_80");
    endtask

    task automatic test_gaps;
        send_frame(f_mix, 1'b1, 1'b0);
        collect("gaps");
        release_out("gaps");
    endtask

    task automatic test_backpressure;
        exp_t e;
        e = model(f_mix);
        send_frame(f_mix, 1'b0, 1'b0);
        collect("bp");
        for (int k = 0; k < 5; k++) begin
            tick;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_max !== e.max) begin
                $display("FAIL bp_hold_%0d: vld=%b sum=%0d max=%0d want 1/%0d/%0d",
                         k, bus.out_valid, bus.out_sum, bus.out_max, e.sum, e.max);
                n_err++;
            end
        end
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            $display("FAIL bp_start_in_done: vld=%b rdy=%b want 1/0", bus.out_valid, bus.in_ready);
            n_err++;
        end
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
                bus.out_sum !== e.sum || bus.out_max !== e.max) begin
                $display("FAIL bp_idle_%0d: vld=%b rdy=%b busy=%b sum=%0d max=%0d want 0/0/0/%0d/%0d",
                         k, bus.out_valid, bus.in_ready, bus.busy, bus.out_sum, bus.out_max, e.sum, e.max);
                n_err++;
            end
            tick;
        end
    endtask

    task automatic test_reset_midframe;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i * 16);
            tick;
        end
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_sum !== '0 || bus.out_max !== '0) begin
            $display("FAIL async_reset: rdy=%b vld=%b busy=%b sum=%0d max=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_sum, bus.out_max);
            n_err++;
        end
        tick;
        rst = 1'b0;
        tick;
        send_frame(f_02, 1'b0, 1'b0);
        collect("after_reset");
        release_out("after_reset");
    endtask

    task automatic test_idle_valid;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7F;
        for (int k = 0; k < 3; k++) begin
            tick;
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_sum !== 11'd16) begin
                $display("FAIL idle_valid_%0d: rdy=%b busy=%b sum=%0d want 0/0/16",
                         k, bus.in_ready, bus.busy, bus.out_sum);
                n_err++;
            end
        end
        bus.in_valid = 1'b0;
        send_frame(f_ff, 1'b0, 1'b0);
        collect("idle_valid");
        release_out("idle_valid");
    endtask

    task automatic test_start_in_accum;
        send_frame(f_mix, 1'b0, 1'b1);
        collect("start_in_accum");
        release_out("start_in_accum");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        f_ff  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        f_mix = '{8'hFF, 8'h00, 8'hD5, 8'h76, 8'h80, 8'h7F, 8'h01, 8'hFE};
        f_80  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        f_02  = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};

        test_reset;
        test_basic;
        test_gaps;
        test_backpressure;
        test_reset_midframe;
        test_idle_valid;
        test_start_in_accum;

        n_cmp++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
            n_err++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
